// File: rtl/eth_pkg.sv
// Shared constants and FSM encoding for the Ethernet/UDP transmit path.
package eth_pkg;

    localparam int unsigned CLK_HZ          = 125_000_000;
    localparam int unsigned MAX_UDP_PAYLOAD = 1472;
    localparam int unsigned ETH_IFG         = 12;
    localparam int unsigned IDLE_TIMEOUT    = CLK_HZ / 100_000;  // 10 us
    localparam int unsigned LEN_W           = 16;
    localparam int unsigned BYTE_W          = 8;

    typedef enum logic [4:0] {
        ST_IDLE   = 5'b00001,
        ST_ACCUM  = 5'b00010,
        ST_LAUNCH = 5'b00100,
        ST_SEND   = 5'b01000,
        ST_GAP    = 5'b10000
    } pkt_state_e;

endpackage

// File: rtl/payload_fifo_fwft.sv
// Synchronous show-ahead byte FIFO; the head byte is readable with no pop latency.
module payload_fifo_fwft
    import eth_pkg::*;
#(
    parameter int unsigned ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [BYTE_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [BYTE_W-1:0] rd_data,
    output logic              full,
    output logic              empty
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [BYTE_W-1:0] r_mem [DEPTH];
    logic [ADDR_W:0]   r_wr_ptr;
    logic [ADDR_W:0]   r_rd_ptr;
    logic              w_wr;
    logic              w_rd;

    assign w_wr  = wr_en && !full;
    assign w_rd  = rd_en && !empty;
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                   (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);

    // Head is forced to zero when empty so a stray pop never sees stale data.
    assign rd_data = empty ? '0 : r_mem[r_rd_ptr[ADDR_W-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + (ADDR_W+1)'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + (ADDR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr[ADDR_W-1:0]] <= wr_data;
    end

endmodule

// File: rtl/udp_payload_packer.sv
// Buffers an input byte stream and hands it to the UDP transmitter in packets,
// cut by byte count, end-of-message marker or idle timeout.
module udp_payload_packer
    import eth_pkg::*;
#(
    parameter int unsigned ADDR_W  = 11,
    parameter int unsigned MAX_LEN = MAX_UDP_PAYLOAD,
    parameter int unsigned TIMEOUT = IDLE_TIMEOUT,
    parameter int unsigned IFG     = ETH_IFG
) (
    input  logic              clk125M,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              tx_en_pulse_o,
    output logic [LEN_W-1:0]  data_length_o,
    input  logic              payload_req_i,
    output logic [BYTE_W-1:0] payload_dat_o,
    input  logic              tx_done_i,
    output logic [31:0]       pkt_cnt_o,
    output logic              err_o
);

    localparam int unsigned IDLE_W = $clog2(TIMEOUT);
    localparam int unsigned GAP_W  = (IFG > 2) ? $clog2(IFG) : 1;

    pkt_state_e        r_state;
    pkt_state_e        w_state_nxt;
    logic [LEN_W-1:0]  r_pend_len;
    logic [LEN_W-1:0]  r_len_q;
    logic [LEN_W-1:0]  r_remain;
    logic [IDLE_W-1:0] r_idle_cnt;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic [31:0]       r_pkt_cnt;
    logic              r_last_hold;
    logic              r_err;

    logic [LEN_W-1:0]  w_pend_len_nxt;
    logic              w_last_hold_nxt;
    logic              w_full;
    logic              w_empty;
    logic              w_accept;
    logic              w_trigger;
    logic              w_launch_now;
    logic              w_pop;
    logic              w_err;
    logic              w_gap_done;
    logic              w_in_accum;
    logic              w_in_launch;
    logic              w_in_send;
    logic              w_in_gap;
    logic [BYTE_W-1:0] w_fifo_dat;

    payload_fifo_fwft #(.ADDR_W(ADDR_W)) u_fifo (
        .clk     (clk125M),
        .rst     (reset),
        .wr_en   (w_accept),
        .wr_data (in_data),
        .rd_en   (w_pop),
        .rd_data (w_fifo_dat),
        .full    (w_full),
        .empty   (w_empty)
    );

    assign in_ready = !reset && !w_full && !r_last_hold && (r_pend_len != LEN_W'(MAX_LEN));
    assign w_accept = in_valid && in_ready;

    assign w_pend_len_nxt  = r_pend_len + LEN_W'(w_accept);
    assign w_last_hold_nxt = r_last_hold || (w_accept && in_last);

    // Packet boundary decision on next-cycle values; never an empty packet.
    assign w_trigger = (w_pend_len_nxt != '0) &&
                       ((w_pend_len_nxt == LEN_W'(MAX_LEN)) || w_last_hold_nxt ||
                        ((r_idle_cnt == IDLE_W'(TIMEOUT - 1)) && (r_pend_len != '0)));

    assign w_launch_now = w_in_accum && w_trigger;
    assign w_gap_done   = (r_gap_cnt == GAP_W'(IFG - 2));
    assign w_pop        = payload_req_i && w_in_send && (r_remain != '0) && !w_empty;

    assign w_err = (payload_req_i && (!w_in_send || (r_remain == '0) || w_empty)) ||
                   (tx_done_i && (!w_in_send || (r_remain != '0)));

    // State register
    always_ff @(posedge clk125M) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   w_state_nxt = ST_ACCUM;
            ST_ACCUM:  if (w_trigger) w_state_nxt = ST_LAUNCH;
            ST_LAUNCH: w_state_nxt = ST_SEND;
            ST_SEND:   if (tx_done_i) w_state_nxt = ST_GAP;
            ST_GAP:    if (w_gap_done) w_state_nxt = ST_ACCUM;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // State decode
    always_comb begin
        w_in_accum  = 1'b0;
        w_in_launch = 1'b0;
        w_in_send   = 1'b0;
        w_in_gap    = 1'b0;
        case (r_state)
            ST_ACCUM:  w_in_accum  = 1'b1;
            ST_LAUNCH: w_in_launch = 1'b1;
            ST_SEND:   w_in_send   = 1'b1;
            ST_GAP:    w_in_gap    = 1'b1;
            default:   ;
        endcase
    end

    // Accumulation, packet bookkeeping and error capture
    always_ff @(posedge clk125M) begin
        if (reset) begin
            r_pend_len  <= '0;
            r_len_q     <= '0;
            r_remain    <= '0;
            r_idle_cnt  <= '0;
            r_gap_cnt   <= '0;
            r_pkt_cnt   <= '0;
            r_last_hold <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (w_launch_now) begin
                r_len_q     <= w_pend_len_nxt;
                r_pend_len  <= '0;
                r_last_hold <= 1'b0;
                r_idle_cnt  <= '0;
            end else begin
                r_pend_len  <= w_pend_len_nxt;
                r_last_hold <= w_last_hold_nxt;
                if (w_accept || (r_pend_len == '0))
                    r_idle_cnt <= '0;
                else if (r_idle_cnt != IDLE_W'(TIMEOUT - 1))
                    r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
            end

            if (w_in_launch)  r_remain <= r_len_q;
            else if (w_pop)   r_remain <= r_remain - LEN_W'(1);

            if (w_in_launch)  r_pkt_cnt <= r_pkt_cnt + 32'd1;

            if (w_in_send && tx_done_i) r_gap_cnt <= '0;
            else if (w_in_gap)          r_gap_cnt <= r_gap_cnt + GAP_W'(1);

            if (w_err) r_err <= 1'b1;
        end
    end

    assign tx_en_pulse_o = w_in_launch;
    assign data_length_o = r_len_q;
    assign payload_dat_o = w_fifo_dat;
    assign pkt_cnt_o     = r_pkt_cnt;
    assign err_o         = r_err;

endmodule

// File: tb/tb_udp_payload_packer.sv
// Directed bench for udp_payload_packer with a popping transmitter model and byte scoreboard.
module tb_udp_payload_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;
    logic        in_ready;
    logic        tx_en_pulse_o;
    logic [15:0] data_length_o;
    logic        payload_req_i;
    logic [7:0]  payload_dat_o;
    logic        tx_done_i;
    logic [31:0] pkt_cnt_o;
    logic        err_o;

    logic model_req  = 1'b0;
    logic model_done = 1'b0;
    logic inj_req    = 1'b0;
    logic inj_done   = 1'b0;

    assign payload_req_i = model_req | inj_req;
    assign tx_done_i     = model_done | inj_done;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [7:0] exp_q[$];
    int pulse_cyc[$];
    int pkt_len[$];
    int done_cyc[$];

    int pop_limit    = 0;
    int done_hold    = 1;
    bit aborted      = 1'b0;
    bit bp_seen      = 1'b0;
    int last_acc_cyc = 0;

    udp_payload_packer dut (
        .clk125M       (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_last       (in_last),
        .in_ready      (in_ready),
        .tx_en_pulse_o (tx_en_pulse_o),
        .data_length_o (data_length_o),
        .payload_req_i (payload_req_i),
        .payload_dat_o (payload_dat_o),
        .tx_done_i     (tx_done_i),
        .pkt_cnt_o     (pkt_cnt_o),
        .err_o         (err_o)
    );

    always #4 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Streams n bytes base, base+1, ...; optional in_last on the final byte.
    task automatic send_bytes(input int n, input int base, input bit last_end);
        for (int i = 0; i < n; i++) begin
            int w;
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_data  = 8'(base + i);
            in_last  = last_end && (i == n - 1);
            w = 0;
            @(negedge clk);
            while (!in_ready && w < 20000) begin
                bp_seen = 1'b1;
                w++;
                @(negedge clk);
            end
            if (!in_ready) begin
                check_eq("in_ready_wait", 32'(in_ready), 32'd1);
                break;
            end
            exp_q.push_back(in_data);
            last_acc_cyc = cyc;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done(input int n, input int budget, input string tag);
        int k = 0;
        while (done_cyc.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (done_cyc.size() < n) check_eq(tag, 32'(done_cyc.size()), 32'(n));
    endtask

    // Transmitter model: pops len bytes back-to-back after each start pulse.
    initial begin : tx_model
        int len;
        int npop;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (tx_en_pulse_o) begin
                len = int'(data_length_o);
                pulse_cyc.push_back(cyc);
                pkt_len.push_back(len);
                npop = (pop_limit != 0 && pop_limit < len) ? pop_limit : len;
                for (int i = 0; i < npop; i++) begin
                    @(posedge clk); #1;
                    model_req = 1'b1;
                    @(negedge clk);
                    if (exp_q.size() == 0) begin
                        check_eq("rx_extra_byte", 32'(payload_dat_o), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("rx_byte", 32'(payload_dat_o), 32'(e));
                    end
                end
                @(posedge clk); #1;
                model_req = 1'b0;
                if (npop < len) begin
                    aborted = 1'b1;
                end else begin
                    repeat (done_hold) begin
                        @(posedge clk); #1;
                    end
                    model_done = 1'b1;
                    @(negedge clk);
                    done_cyc.push_back(cyc);
                    @(posedge clk); #1;
                    model_done = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #(8 * 90000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int base;
        int la;
        int k;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;

        // Reset behaviour
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_in_ready_low", 32'(in_ready), 32'd0);
        check_eq("rst_pkt_cnt", pkt_cnt_o, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("post_rst_tx_en", 32'(tx_en_pulse_o), 32'd0);
        check_eq("post_rst_len", 32'(data_length_o), 32'd0);
        check_eq("post_rst_err", 32'(err_o), 32'd0);
        check_eq("post_rst_dat", 32'(payload_dat_o), 32'd0);

        // 1: 100-byte message terminated by in_last
        send_bytes(100, 0, 1'b1);
        wait_done(1, 3000, "t1_done_timeout");
        check_eq("t1_len", 32'(pkt_len[0]), 32'd100);
        check_eq("t1_pkt_cnt", pkt_cnt_o, 32'd1);
        check_eq("t1_err", 32'(err_o), 32'd0);
        check_eq("t1_all_bytes_out", 32'(exp_q.size()), 32'd0);

        // 2: 3000 contiguous bytes, split by count then timeout
        bp_seen = 1'b0;
        send_bytes(3000, 0, 1'b0);
        la = last_acc_cyc;
        wait_done(4, 12000, "t2_done_timeout");
        check_eq("t2_len_a", 32'(pkt_len[1]), 32'd1472);
        check_eq("t2_len_b", 32'(pkt_len[2]), 32'd1472);
        check_eq("t2_len_c", 32'(pkt_len[3]), 32'd56);
        check_eq("t2_backpressure", 32'(bp_seen), 32'd1);
        check_eq("t2_flush_after_timeout", 32'(pulse_cyc[3] - la >= 1250), 32'd1);
        check_eq("t2_pkt_cnt", pkt_cnt_o, 32'd4);
        check_eq("t2_err", 32'(err_o), 32'd0);

        // 3: short message flushed by idle timeout
        send_bytes(5, 8'h30, 1'b0);
        la = last_acc_cyc;
        wait_done(5, 4000, "t3_done_timeout");
        check_eq("t3_len", 32'(pkt_len[4]), 32'd5);
        check_eq("t3_timeout_cycles", 32'(pulse_cyc[4] - la), 32'd1251);

        // 4: done held off while the next full packet accumulates
        done_hold = 2000;
        send_bytes(2944, 8'h11, 1'b0);
        wait_done(6, 8000, "t4_done_a_timeout");
        done_hold = 1;
        wait_done(7, 4000, "t4_done_b_timeout");
        check_eq("t4_len_a", 32'(pkt_len[5]), 32'd1472);
        check_eq("t4_len_b", 32'(pkt_len[6]), 32'd1472);
        check_eq("t4_ifg", 32'(pulse_cyc[6] - done_cyc[5]), 32'd13);
        check_eq("t4_all_bytes_out", 32'(exp_q.size()), 32'd0);
        check_eq("t4_err", 32'(err_o), 32'd0);

        // 5: protocol errors while accumulating
        check_eq("t5_empty_dat", 32'(payload_dat_o), 32'd0);
        @(posedge clk); #1;
        inj_req = 1'b1;
        @(posedge clk); #1;
        inj_req = 1'b0;
        @(negedge clk);
        check_eq("t5_err_pop_empty", 32'(err_o), 32'd1);
        @(posedge clk); #1;
        inj_done = 1'b1;
        @(posedge clk); #1;
        inj_done = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("t5_err_sticky", 32'(err_o), 32'd1);
        send_bytes(7, 8'h70, 1'b1);
        wait_done(8, 2000, "t5_done_timeout");
        check_eq("t5_len", 32'(pkt_len[7]), 32'd7);
        check_eq("t5_err_still", 32'(err_o), 32'd1);

        // 6: reset in the middle of SEND
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq("t6_err_cleared", 32'(err_o), 32'd0);
        pop_limit = 40;
        aborted   = 1'b0;
        base      = pkt_len.size();
        send_bytes(100, 8'h80, 1'b1);
        k = 0;
        while (!aborted && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check_eq("t6_reached_40_pops", 32'(aborted), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check_eq("t6_in_ready_in_reset", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq("t6_tx_en", 32'(tx_en_pulse_o), 32'd0);
        check_eq("t6_len_zero", 32'(data_length_o), 32'd0);
        check_eq("t6_pkt_cnt_zero", pkt_cnt_o, 32'd0);
        check_eq("t6_dat_empty", 32'(payload_dat_o), 32'd0);
        check_eq("t6_err", 32'(err_o), 32'd0);
        check_eq("t6_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        pop_limit = 0;
        send_bytes(10, 8'hA0, 1'b1);
        wait_done(done_cyc.size() + 1, 2000, "t6_done_timeout");
        check_eq("t6_len", 32'(pkt_len[base + 1]), 32'd10);
        check_eq("t6_pkt_cnt", pkt_cnt_o, 32'd1);
        check_eq("t6_err_end", 32'(err_o), 32'd0);
        check_eq("t6_all_bytes_out", 32'(exp_q.size()), 32'd0);

        repeat (5) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
